// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared state encoding and protocol byte codes for matrix_loader
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_TARGET  = 3'd1,
        ST_DATA    = 3'd2,
        ST_CSUM    = 3'd3,
        ST_REPLY   = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_START   = 3'd6,
        ST_BUSY    = 3'd7
    } state_t;

    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;
    localparam logic [7:0] TARGET_A = 8'h00;
    localparam logic [7:0] TARGET_B = 8'h01;

endpackage

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - UART frame parser loading matrices A/B for matrix_mult, ACK/NAK reply, start handoff
// Optional inter-byte timeout: define MATRIX_LOADER_TIMEOUT_EN.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int         DIM            = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    output logic       a_we,
    output logic [7:0] a_waddr,
    output logic [7:0] a_wdata,
    output logic       b_we,
    output logic [7:0] b_waddr,
    output logic [7:0] b_wdata,
    output logic       start,
    input  logic       done,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       tx_active,
    output logic [2:0] status
);

    localparam logic [3:0] LAST = 4'(DIM - 1);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic [3:0] row_q, row_d, col_q, col_d;
    logic [7:0] csum_q, csum_d;
    logic       loaded_a_q, loaded_a_d, loaded_b_q, loaded_b_d;
    logic [7:0] reply_q, reply_d;
    logic       wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
    logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic       tx_dv_q, tx_dv_d;
    logic [7:0] tx_byte_q, tx_byte_d;

`ifdef MATRIX_LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        parsing;
    assign parsing = (state_q == ST_TARGET) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign tmo_d   = (parsing && !rx_dv) ? tmo_q + 32'd1 : 32'd0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        row_d      = row_q;
        col_d      = col_q;
        csum_d     = csum_q;
        loaded_a_d = loaded_a_q;
        loaded_b_d = loaded_b_q;
        reply_d    = reply_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        case (state_q)
            ST_HUNT: if (rx_dv && rx_byte == SYNC_BYTE) state_d = ST_TARGET;
            ST_TARGET: if (rx_dv) begin
                if (rx_byte == TARGET_A || rx_byte == TARGET_B) begin
                    sel_d   = (rx_byte == TARGET_B);
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    csum_d  = 8'd0;
                    state_d = ST_DATA;
                end else begin
                    reply_d = NAK;
                    state_d = ST_REPLY;
                end
            end
            ST_DATA: if (rx_dv) begin
                wr_en_d   = 1'b1;
                wr_sel_d  = sel_q;
                wr_addr_d = {row_q, col_q};
                wr_data_d = rx_byte;
                csum_d    = csum_q ^ rx_byte;
                // Any overwrite of a matrix invalidates the copy held in memory.
                if (row_q == 4'd0 && col_q == 4'd0) begin
                    if (sel_q) loaded_b_d = 1'b0;
                    else       loaded_a_d = 1'b0;
                end
                if (col_q == LAST) begin
                    col_d = 4'd0;
                    if (row_q == LAST) state_d = ST_CSUM;
                    else               row_d   = row_q + 4'd1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            ST_CSUM: if (rx_dv) begin
                if (sel_q) loaded_b_d = (rx_byte == csum_q);
                else       loaded_a_d = (rx_byte == csum_q);
                reply_d = (rx_byte == csum_q) ? ACK : NAK;
                state_d = ST_REPLY;
            end
            ST_REPLY: if (!tx_active) begin
                tx_dv_d   = 1'b1;
                tx_byte_d = reply_q;
                state_d   = ST_WAIT_TX;
            end
            ST_WAIT_TX: if (tx_done) state_d = (loaded_a_q && loaded_b_q) ? ST_START : ST_HUNT;
            ST_START: state_d = ST_BUSY;
            ST_BUSY: if (done) begin
                loaded_a_d = 1'b0;
                loaded_b_d = 1'b0;
                state_d    = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase
`ifdef MATRIX_LOADER_TIMEOUT_EN
        if (parsing && !rx_dv && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
            if (state_q != ST_TARGET) begin
                if (sel_q) loaded_b_d = 1'b0;
                else       loaded_a_d = 1'b0;
            end
            reply_d = NAK;
            state_d = ST_REPLY;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            sel_q      <= 1'b0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            csum_q     <= 8'd0;
            loaded_a_q <= 1'b0;
            loaded_b_q <= 1'b0;
            reply_q    <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'd0;
`ifdef MATRIX_LOADER_TIMEOUT_EN
            tmo_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            row_q      <= row_d;
            col_q      <= col_d;
            csum_q     <= csum_d;
            loaded_a_q <= loaded_a_d;
            loaded_b_q <= loaded_b_d;
            reply_q    <= reply_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
`ifdef MATRIX_LOADER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign a_we    = wr_en_q & ~wr_sel_q;
    assign b_we    = wr_en_q & wr_sel_q;
    assign a_waddr = wr_addr_q;
    assign b_waddr = wr_addr_q;
    assign a_wdata = wr_data_q;
    assign b_wdata = wr_data_q;
    assign start   = (state_q == ST_START);
    assign tx_dv   = tx_dv_q;
    assign tx_byte = tx_byte_q;
    assign status  = state_q;

endmodule
